// File: rtl/cpu6_skid_buf.sv
// Two-entry elastic pipeline register between cpu6 stages; i_ready is taken
// straight from the skid-valid flop so no combinational path runs from o_ready.
module cpu6_skid_buf #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    // Encoding is {main valid, skid valid}; (0,1) is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          in_acc, out_acc;
    logic          ld_main_in, ld_main_skid, ld_skid;

    assign o_valid = state_q[1];
    assign i_ready = ~state_q[0];
    assign o_data  = main_q;
    assign in_acc  = i_valid & i_ready;
    assign out_acc = o_valid & o_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_acc) begin
                    state_d    = BUSY;
                    ld_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (in_acc && out_acc) begin
                    ld_main_in = 1'b1;
                end else if (in_acc) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (out_acc) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_acc) begin
                    state_d      = BUSY;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything; a same-cycle output accept has already completed.
        if (flush) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
        end else if (ld_main_in) begin
            main_q <= i_data;
        end else if (ld_main_skid) begin
            main_q <= skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_skid) begin
            skid_q <= i_data;
        end
    end

    always_comb begin
        case (state_q)
            BUSY:    o_count = 2'd1;
            FULL:    o_count = 2'd2;
            default: o_count = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_cpu6_skid_buf.sv
// Directed vector table plus hand-written flush/async-reset sequences and a
// randomised handshake run against a scoreboard for cpu6_skid_buf.
module tb_cpu6_skid_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic [1:0]  o_count;

    int total = 0;
    int bad   = 0;

    cpu6_skid_buf #(.DW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] d;
        logic        eov;
        logic        eir;
        logic [1:0]  ecnt;
        logic        dchk;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(logic fl, logic iv, logic ordy, logic [31:0] d,
                                 logic eov, logic eir, logic [1:0] ecnt,
                                 logic dchk, logic [31:0] ed);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d;
        v.eov = eov; v.eir = eir; v.ecnt = ecnt; v.dchk = dchk; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input logic eov, input logic eir,
                             input logic [1:0] ecnt);
        chk({tag, ".o_valid"}, {31'd0, o_valid}, {31'd0, eov});
        chk({tag, ".i_ready"}, {31'd0, i_ready}, {31'd0, eir});
        chk({tag, ".o_count"}, {30'd0, o_count}, {30'd0, ecnt});
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        flush   = v.fl;
        i_valid = v.iv;
        o_ready = v.ordy;
        i_data  = v.d;
        @(posedge clk);
        #1;
        tag = $sformatf("vec%0d", idx);
        chk_state(tag, v.eov, v.eir, v.ecnt);
        if (v.dchk) chk({tag, ".o_data"}, o_data, v.ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int unsigned tx, rx, occ, sent_words;
        logic in_acc, out_acc;

        rst = 1'b1; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = '0;
        #3;
        chk_state("reset", 1'b0, 1'b1, 2'd0);
        chk("reset.o_data", o_data, 32'h0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Streaming at full rate.
        for (int k = 0; k < 8; k++)
            addv(0, 1, 1, 32'h10 + k, 1, 1, 2'd1, 1, 32'h10 + k);
        addv(0, 0, 1, 32'h0, 0, 1, 2'd0, 0, 32'h0);
        // Back-pressure into FULL, blocked input, then drain.
        addv(0, 1, 1, 32'hA1, 1, 1, 2'd1, 1, 32'hA1);
        addv(0, 1, 0, 32'hA2, 1, 0, 2'd2, 1, 32'hA1);
        addv(0, 1, 0, 32'hAA, 1, 0, 2'd2, 1, 32'hA1);
        addv(0, 0, 0, 32'h0,  1, 0, 2'd2, 1, 32'hA1);
        addv(0, 0, 1, 32'h0,  1, 1, 2'd1, 1, 32'hA2);
        addv(0, 0, 1, 32'h0,  0, 1, 2'd0, 0, 32'h0);
        // Flush in FULL with a concurrent input; 0xB3 must never show.
        addv(0, 1, 0, 32'hB1, 1, 1, 2'd1, 1, 32'hB1);
        addv(0, 1, 0, 32'hB2, 1, 0, 2'd2, 1, 32'hB1);
        addv(1, 1, 0, 32'hB3, 0, 1, 2'd0, 0, 32'h0);
        addv(0, 0, 1, 32'h0,  0, 1, 2'd0, 0, 32'h0);
        // Flush in BUSY with both accepts active.
        addv(0, 1, 0, 32'hD1, 1, 1, 2'd1, 1, 32'hD1);
        addv(1, 1, 1, 32'hD2, 0, 1, 2'd0, 0, 32'h0);
        addv(0, 0, 0, 32'h0,  0, 1, 2'd0, 0, 32'h0);
        // Refill to FULL ahead of the async reset sequence.
        addv(0, 1, 0, 32'hE1, 1, 1, 2'd1, 1, 32'hE1);
        addv(0, 1, 0, 32'hE2, 1, 0, 2'd2, 1, 32'hE1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Async reset mid-cycle while FULL.
        i_valid = 1'b0; o_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst", 1'b0, 1'b1, 2'd0);
        #2 rst = 1'b0;
        i_valid = 1'b1; i_data = 32'hC0; o_ready = 1'b1;
        @(posedge clk); #1;
        chk_state("post_rst", 1'b1, 1'b1, 2'd1);
        chk("post_rst.o_data", o_data, 32'hC0);
        i_valid = 1'b0;
        @(posedge clk); #1;
        chk_state("post_rst_drain", 1'b0, 1'b1, 2'd0);

        // Random handshake run with incrementing payload.
        tx = 0; rx = 0; occ = 0; sent_words = 0;
        for (int c = 0; c < 10000; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            o_ready = 1'($urandom_range(0, 1));
            i_data  = 32'h1000 + tx;
            @(negedge clk);
            chk("rnd.o_count", {30'd0, o_count}, occ[31:0]);
            if (i_ready == 1'b0 && o_count != 2'd2)
                chk("rnd.i_ready_low", {31'd0, i_ready}, 32'd1);
            in_acc  = i_valid & i_ready;
            out_acc = o_valid & o_ready;
            if (out_acc) begin
                chk("rnd.o_data", o_data, 32'h1000 + rx);
                rx++;
            end
            if (in_acc) tx++;
            occ = occ + (in_acc ? 1 : 0) - (out_acc ? 1 : 0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0; o_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_valid) begin
                chk("drain.o_data", o_data, 32'h1000 + rx);
                rx++;
            end
            @(posedge clk); #1;
        end
        sent_words = tx;
        chk("rnd.lossless", rx, sent_words);
        chk_state("rnd.final", 1'b0, 1'b1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu6_skid_buf.md
# cpu6_skid_buf

Two-entry elastic pipeline register with a valid/ready handshake on both sides. It is built from the cpu6 load-enable flop primitives and sits between adjacent cpu6 pipeline stages, such as fetch to decode or decode to execute. It breaks the combinational ready path: `i_ready` is driven only from local state, never from `o_ready`. It sustains one transfer per cycle and holds data stable under back-pressure.

## Interface
Parameters:
- `DW`, default 32: payload width in bits.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `flush`  input  1  synchronous pipeline flush; discards all held entries.
- `i_valid`  input  1  upstream has data on `i_data`.
- `i_ready`  output  1  buffer can accept. Equals NOT skid-entry-valid, a pure register output.
- `i_data`  input  DW  upstream payload.
- `o_valid`  output  1  main entry holds data. Registered.
- `o_ready`  input  1  downstream accepts this cycle.
- `o_data`  output  DW  main entry payload. Registered.
- `o_count`  output  2  occupancy: 0, 1 or 2.

## Operation
- Storage:
  - main entry (`o_data`, `o_valid`)
  - skid entry (`skid_data`, `skid_vld`)
- Input accept: `i_valid & i_ready`.
- Output accept: `o_valid & o_ready`.
- States, derived from the two valid bits:
  - EMPTY (0,0)
  - BUSY (1,0)
  - FULL (1,1)
  - (0,1) is illegal and must never occur.
- Transitions, when `flush` = 0:
  - EMPTY + input accept -> BUSY; main <= `i_data`.
  - BUSY + input accept + output accept -> BUSY; main <= `i_data`.
  - BUSY + input accept, no output accept -> FULL; skid <= `i_data`; main unchanged.
  - BUSY + output accept, no input accept -> EMPTY.
  - FULL: `i_ready` = 0, so no input accept is possible. Output accept -> BUSY; main <= skid. Otherwise hold.
  - No accept event: all state holds.
- Flush:
  - `flush` = 1 forces the next state to EMPTY, with both valid bits cleared.
  - A same-cycle input accept is discarded.
  - A same-cycle output accept still counts as a completed transfer for downstream.
  - Flush has priority over every other transition.
- Ordering: strict FIFO. The skid entry is always older than any subsequent input.
- Data registers use load-enable only, with no reset. Valid bits use async reset.
- `o_count` = `o_valid` + `skid_vld`.

## Timing
- Reset values:
  - `o_valid` = 0
  - `skid_vld` = 0
  - `i_ready` = 1
  - `o_count` = 0
  - `o_data` = 0; this data register does use reset, for clean simulation.
- Reset asserted mid-operation: valids clear immediately, asynchronously. Data in flight is lost.
- Latency: an input accepted at edge N appears with `o_valid` = 1 after edge N, so it is visible in cycle N+1.
- Throughput: one transfer per cycle when `o_ready` is held high.
- Back-pressure:
  - When `o_valid` = 1 and `o_ready` = 0, `o_data` and `o_valid` stay unchanged.
  - `i_ready` falls exactly one cycle after the first un-accepted output while a new input was taken.
  - `i_ready` rises in the cycle after the FULL -> BUSY drain.
- `i_ready` never depends combinationally on `o_ready`, `i_valid` or `flush`.
- Upstream may drop or change `i_valid` or `i_data` when `i_ready` = 0. No loss occurs, because nothing is accepted.

## Test plan
- Reset, then stream 8 words 0x10..0x17 with `o_ready` = 1:
  - `o_data` shows 0x10..0x17 on consecutive cycles, starting one cycle after the first accept.
  - `i_ready` stays 1 throughout.
  - `o_count` stays at 1 or below.
- Back-pressure: `o_valid` holds 0xA1, then `o_ready` = 0 while 0xA2 is accepted.
  - Next cycle: `i_ready` = 0, `o_count` = 2, `o_data` = 0xA1.
  - Raise `o_ready`: output sequence is 0xA1 then 0xA2, with `i_ready` = 1 one cycle after the drain.
- Random `i_valid`/`o_ready` for 10k cycles with an incrementing payload:
  - Scoreboard sees in-order, lossless, duplicate-free output.
  - `i_ready` never equals 0 while `o_count` < 2.
- Flush in FULL (0xB1, 0xB2 held) together with `i_valid` = 1 on 0xB3:
  - Next cycle: `o_valid` = 0, `o_count` = 0, `i_ready` = 1.
  - 0xB3 never appears.
- Assert `rst` asynchronously mid-cycle while FULL:
  - `o_valid` = 0 and `i_ready` = 1 immediately, without waiting for a clock edge.
  - The first post-reset input 0xC0 emerges after one cycle.
